// File: rtl/neuron_bus_master_pkg.sv
// Shared state encoding, default widths and latency limit for the neuron bus master.
package neuron_bus_master_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int MAX_READ_LATENCY   = 7;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRANT     = 3'd1,
    WRITE     = 3'd2,
    READ_WAIT = 3'd3,
    RESPOND   = 3'd4,
    RELEASE   = 3'd5
  } state_t;

  // Where an accepted command goes once the bus is already granted.
  function automatic state_t dispatch_state(input logic is_write);
    return is_write ? WRITE : READ_WAIT;
  endfunction

endpackage

// File: rtl/neuron_bus_master.sv
// Host-command to neuron-memory bus master: requests the external arbiter side,
// performs single writes or latency-timed reads, and chains back-to-back commands.
module neuron_bus_master
  import neuron_bus_master_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_address,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  input  logic [DATA_WIDTH-1:0] neuron_read_data,
  output logic                  select_external,
  output logic [ADDR_WIDTH-1:0] neuron_read_address_ext,
  output logic [ADDR_WIDTH-1:0] neuron_write_address_ext,
  output logic [DATA_WIDTH-1:0] neuron_write_data_ext,
  output logic                  neuron_write_enable_ext,
  output logic                  busy
);

  // Out-of-range latencies are clamped so the 3-bit counter always terminates.
  localparam int EFF_LATENCY = (READ_LATENCY < 1) ? 1 :
                               ((READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY);
  localparam logic [2:0] LAST_WAIT = 3'(EFF_LATENCY - 1);

  state_t     state;
  logic [2:0] wait_count;
  logic       latched_write;
  logic       accept;

  // cmd_ready is combinational so a RESPOND handshake can chain the next command.
  always_comb begin
    cmd_ready = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE, WRITE: cmd_ready = 1'b1;
        RESPOND:     cmd_ready = rsp_ready;
        default:     cmd_ready = 1'b0;
      endcase
    end else begin
      cmd_ready = 1'b0;
    end
  end

  assign accept = cmd_valid && cmd_ready;
  assign busy   = (state != IDLE);

  // Command latching and the transfer sequencer with all bus outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                    <= IDLE;
      wait_count               <= 3'd0;
      latched_write            <= 1'b0;
      select_external          <= 1'b0;
      neuron_write_enable_ext  <= 1'b0;
      rsp_valid                <= 1'b0;
      rsp_data                 <= '0;
      neuron_read_address_ext  <= '0;
      neuron_write_address_ext <= '0;
      neuron_write_data_ext    <= '0;
    end else begin
      if (accept) begin
        neuron_read_address_ext  <= cmd_address;
        neuron_write_address_ext <= cmd_address;
        latched_write            <= cmd_write;
        if (cmd_write) begin
          neuron_write_data_ext <= cmd_data;
        end
      end

      case (state)
        IDLE: begin
          if (accept) begin
            state           <= GRANT;
            select_external <= 1'b1;
          end
        end
        GRANT: begin
          state                   <= dispatch_state(latched_write);
          neuron_write_enable_ext <= latched_write;
          wait_count              <= 3'd0;
        end
        WRITE: begin
          neuron_write_enable_ext <= accept && cmd_write;
          wait_count              <= 3'd0;
          if (accept) begin
            state <= dispatch_state(cmd_write);
          end else begin
            state <= RELEASE;
          end
        end
        READ_WAIT: begin
          if (wait_count == LAST_WAIT) begin
            rsp_data  <= neuron_read_data;
            rsp_valid <= 1'b1;
            state     <= RESPOND;
          end else begin
            wait_count <= wait_count + 3'd1;
          end
        end
        RESPOND: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            wait_count <= 3'd0;
            if (accept) begin
              state                   <= dispatch_state(cmd_write);
              neuron_write_enable_ext <= cmd_write;
            end else begin
              state <= RELEASE;
            end
          end
        end
        RELEASE: begin
          select_external <= 1'b0;
          state           <= IDLE;
        end
        default: begin
          state                   <= IDLE;
          select_external         <= 1'b0;
          neuron_write_enable_ext <= 1'b0;
          rsp_valid               <= 1'b0;
        end
      endcase
    end
  end

endmodule
